// File: rtl/pwm_duty_ramp_ctrl.sv
// rtl/pwm_duty_ramp_ctrl.sv - slews a PWM duty toward a handshaked target at period boundaries
module pwm_duty_ramp_ctrl #(
  parameter int N    = 8,
  parameter int STEP = 1,
  parameter int DIV  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] tgt,
  input  logic         tgt_valid,
  output logic         tgt_ready,
  output logic [N-1:0] duty,
  output logic         period_end,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DN} state_t;

  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [N:0]    STEP_W   = (N+1)'(STEP);
  localparam logic [N-1:0]  CNT_LAST = '1;

  logic [N-1:0]  cnt;
  logic [DW-1:0] divcnt;
  logic [N-1:0]  target;
  logic [N-1:0]  duty_r;
  logic          ready_r;
  state_t        state, state_nxt;

  logic          upd;
  logic          accept;
  logic [N:0]    up_sum;
  logic [N:0]    dn_floor;
  logic [N-1:0]  duty_step;
  logic [N-1:0]  duty_nxt;
  logic [N-1:0]  target_nxt;

  assign period_end = en & (cnt == CNT_LAST);
  assign upd        = period_end & (divcnt == DIV_LAST);
  assign accept     = tgt_valid & ready_r;
  assign tgt_ready  = ready_r;
  assign duty       = duty_r;

  // Step computed one bit wider so the ramp clamps at target instead of wrapping.
  always_comb begin
    up_sum    = {1'b0, duty_r} + STEP_W;
    dn_floor  = {1'b0, target} + STEP_W;
    duty_step = duty_r;
    if (target > duty_r) begin
      duty_step = (up_sum > {1'b0, target}) ? target : up_sum[N-1:0];
    end else if (target < duty_r) begin
      duty_step = ({1'b0, duty_r} < dn_floor) ? target : (duty_r - STEP_W[N-1:0]);
    end
  end

  // The step above uses the pre-edge target, so a same-cycle accept lands one update later.
  always_comb begin
    duty_nxt   = duty_r;
    target_nxt = target;
    if (!en) begin
      duty_nxt   = '0;
      target_nxt = '0;
    end else begin
      if (upd)    duty_nxt   = duty_step;
      if (accept) target_nxt = tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      divcnt  <= '0;
      target  <= '0;
      duty_r  <= '0;
      ready_r <= 1'b0;
    end else begin
      ready_r <= en;
      target  <= target_nxt;
      duty_r  <= duty_nxt;
      if (!en) begin
        cnt    <= '0;
        divcnt <= '0;
      end else begin
        cnt <= cnt + N'(1);
        if (period_end) divcnt <= upd ? '0 : (divcnt + DW'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    if (target_nxt > duty_nxt)      state_nxt = RAMP_UP;
    else if (target_nxt < duty_nxt) state_nxt = RAMP_DN;
  end

  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// tb/tb_pwm_duty_ramp_ctrl.sv - randomized bench for pwm_duty_ramp_ctrl against an integer model
module tb_pwm_duty_ramp_ctrl;

  localparam int N      = 8;
  localparam int MAXV   = (1 << N) - 1;
  localparam int CYCLES = 60000;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [N-1:0] tgt;
  logic         tgt_valid;

  logic         ready_a, pe_a, busy_a;
  logic [N-1:0] duty_a;
  logic         ready_b, pe_b, busy_b;
  logic [N-1:0] duty_b;

  int n_cmp = 0;
  int n_err = 0;

  int step_v [2] = '{4, 1};
  int div_v  [2] = '{1, 3};
  int m_duty [2];
  int m_tgt  [2];
  int m_div  [2];
  int m_cnt;
  bit m_rdy;
  int en_off;

  pwm_duty_ramp_ctrl #(.N(N), .STEP(4), .DIV(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .tgt(tgt), .tgt_valid(tgt_valid),
    .tgt_ready(ready_a), .duty(duty_a), .period_end(pe_a), .busy(busy_a)
  );

  pwm_duty_ramp_ctrl #(.N(N), .STEP(1), .DIV(3)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .tgt(tgt), .tgt_valid(tgt_valid),
    .tgt_ready(ready_b), .duty(duty_b), .period_end(pe_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_duty[i] = 0;
      m_tgt[i]  = 0;
      m_div[i]  = 0;
    end
    m_cnt = 0;
    m_rdy = 1'b0;
  endtask

  // Behaviour at one rising edge, from the pre-edge inputs and model state.
  task automatic model_edge();
    bit pe, acc;
    pe  = en && (m_cnt == MAXV);
    acc = tgt_valid && m_rdy;
    for (int i = 0; i < 2; i++) begin
      if (!en) begin
        m_duty[i] = 0;
        m_tgt[i]  = 0;
        m_div[i]  = 0;
      end else begin
        if (pe) begin
          if (m_div[i] == div_v[i] - 1) begin
            m_div[i] = 0;
            if (m_tgt[i] > m_duty[i])
              m_duty[i] = (m_duty[i] + step_v[i] > m_tgt[i]) ? m_tgt[i] : m_duty[i] + step_v[i];
            else if (m_tgt[i] < m_duty[i])
              m_duty[i] = (m_duty[i] - step_v[i] < m_tgt[i]) ? m_tgt[i] : m_duty[i] - step_v[i];
          end else begin
            m_div[i]++;
          end
        end
        if (acc) m_tgt[i] = int'(tgt);
      end
    end
    m_cnt = en ? ((m_cnt + 1) % (MAXV + 1)) : 0;
    m_rdy = en;
  endtask

  task automatic check_all(input string ph);
    int pe_exp;
    pe_exp = (en && m_cnt == MAXV) ? 1 : 0;
    chk({ph, " a.duty"},       int'(duty_a),  m_duty[0]);
    chk({ph, " a.busy"},       int'(busy_a),  (m_duty[0] != m_tgt[0]) ? 1 : 0);
    chk({ph, " a.tgt_ready"},  int'(ready_a), int'(m_rdy));
    chk({ph, " a.period_end"}, int'(pe_a),    pe_exp);
    chk({ph, " b.duty"},       int'(duty_b),  m_duty[1]);
    chk({ph, " b.busy"},       int'(busy_b),  (m_duty[1] != m_tgt[1]) ? 1 : 0);
    chk({ph, " b.tgt_ready"},  int'(ready_b), int'(m_rdy));
    chk({ph, " b.period_end"}, int'(pe_b),    pe_exp);
  endtask

  function automatic int pick_tgt();
    int r, v;
    r = $urandom_range(0, 9);
    if (r < 4) begin
      v = m_duty[0] + int'($urandom_range(0, 24)) - 12;
      if (v < 0)    v = 0;
      if (v > MAXV) v = MAXV;
    end else if (r < 6) v = 0;
    else if (r < 8)     v = MAXV;
    else                v = int'($urandom_range(0, MAXV));
    return v;
  endfunction

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    tgt       = '0;
    tgt_valid = 1'b0;
    en_off    = 0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    en    = 1'b1;
    @(posedge clk);
    model_edge();

    for (int c = 0; c < CYCLES; c++) begin
      @(negedge clk);
      check_all("run");

      if ($urandom_range(0, 4999) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        #1;
        rst_n = 1'b1;
      end

      if (en_off > 0) begin
        en = 1'b0;
        en_off--;
      end else if ($urandom_range(0, 1999) == 0) begin
        en     = 1'b0;
        en_off = int'($urandom_range(0, 2));
      end else begin
        en = 1'b1;
      end

      if (m_cnt == MAXV) tgt_valid = ($urandom_range(0, 1) == 0);
      else               tgt_valid = ($urandom_range(0, 15) == 0);
      tgt = N'(pick_tgt());

      @(posedge clk);
      model_edge();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
